// File: rtl/dcache_axi_bridge.sv
// Data-cache refill/writeback port to AXI4 master bridge; independent read and write FSMs.
// Optional first-error capture is enabled by defining DCACHE_AXI_BRIDGE_ERR_EN.
module dcache_axi_bridge #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    // cache refill side
    input  logic                  io_cache_bus_r_valid,
    input  logic [63:0]           io_cache_bus_r_bits_raddr,
    output logic [63:0]           io_cache_bus_r_bits_rdata,
    output logic                  io_cache_bus_r_bits_rlast,
    output logic                  io_cache_bus_r_ready,
    // cache writeback side
    input  logic                  io_cache_bus_w_valid,
    input  logic [63:0]           io_cache_bus_w_bits_waddr,
    input  logic [63:0]           io_cache_bus_w_bits_wdata,
    input  logic                  io_cache_bus_w_bits_wlast,
    output logic                  io_cache_bus_w_ready,
    output logic                  io_cache_bus_b_valid,
    input  logic                  io_cache_bus_b_ready,
    // AXI read address / data
    output logic                  io_axi_ar_valid,
    input  logic                  io_axi_ar_ready,
    output logic [AXI_ADDR_W-1:0] io_axi_ar_addr,
    output logic [3:0]            io_axi_ar_id,
    output logic [7:0]            io_axi_ar_len,
    output logic [2:0]            io_axi_ar_size,
    output logic [1:0]            io_axi_ar_burst,
    input  logic                  io_axi_r_valid,
    output logic                  io_axi_r_ready,
    input  logic [63:0]           io_axi_r_data,
    input  logic [1:0]            io_axi_r_resp,
    input  logic                  io_axi_r_last,
    input  logic [3:0]            io_axi_r_id,
    // AXI write address / data / response
    output logic                  io_axi_aw_valid,
    input  logic                  io_axi_aw_ready,
    output logic [AXI_ADDR_W-1:0] io_axi_aw_addr,
    output logic [3:0]            io_axi_aw_id,
    output logic [7:0]            io_axi_aw_len,
    output logic [2:0]            io_axi_aw_size,
    output logic [1:0]            io_axi_aw_burst,
    output logic                  io_axi_w_valid,
    input  logic                  io_axi_w_ready,
    output logic [63:0]           io_axi_w_data,
    output logic [7:0]            io_axi_w_strb,
    output logic                  io_axi_w_last,
    input  logic                  io_axi_b_valid,
    output logic                  io_axi_b_ready,
    input  logic [1:0]            io_axi_b_resp,
    input  logic [3:0]            io_axi_b_id
`ifdef DCACHE_AXI_BRIDGE_ERR_EN
    ,
    output logic                  io_err,
    output logic [63:0]           io_err_addr,
    output logic                  io_err_is_w
`endif
);

    typedef enum logic [1:0] {StRIdle, StRAddr, StRData, StRWait} r_state_e;
    typedef enum logic [1:0] {StWIdle, StWAddr, StWData, StWResp} w_state_e;

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic [63:0] raddr_q, raddr_d;
    logic [63:0] waddr_q, waddr_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state_q <= StRIdle;
            w_state_q <= StWIdle;
            raddr_q   <= '0;
            waddr_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
        end
    end

    // Fixed 2-beat, 8-byte INCR bursts
    assign io_axi_ar_id    = AXI_ID;
    assign io_axi_ar_len   = 8'd1;
    assign io_axi_ar_size  = 3'd3;
    assign io_axi_ar_burst = 2'b01;
    assign io_axi_aw_id    = AXI_ID;
    assign io_axi_aw_len   = 8'd1;
    assign io_axi_aw_size  = 3'd3;
    assign io_axi_aw_burst = 2'b01;
    assign io_axi_w_strb   = 8'hff;

    assign io_axi_ar_addr            = raddr_q[AXI_ADDR_W-1:0];
    assign io_axi_aw_addr            = waddr_q[AXI_ADDR_W-1:0];
    assign io_cache_bus_r_bits_rdata = io_axi_r_data;
    assign io_axi_w_data             = io_cache_bus_w_bits_wdata;
    assign io_axi_w_last             = io_cache_bus_w_bits_wlast;

    always_comb begin
        r_state_d                 = r_state_q;
        raddr_d                   = raddr_q;
        io_axi_ar_valid           = 1'b0;
        io_axi_r_ready            = 1'b0;
        io_cache_bus_r_ready      = 1'b0;
        io_cache_bus_r_bits_rlast = 1'b0;
        unique case (r_state_q)
            StRIdle: begin
                if (io_cache_bus_r_valid) begin
                    raddr_d   = io_cache_bus_r_bits_raddr;
                    r_state_d = StRAddr;
                end
            end
            StRAddr: begin
                io_axi_ar_valid = 1'b1;
                if (io_axi_ar_ready) r_state_d = StRData;
            end
            StRData: begin
                io_axi_r_ready            = 1'b1;
                io_cache_bus_r_ready      = io_axi_r_valid;
                io_cache_bus_r_bits_rlast = io_axi_r_valid & io_axi_r_last;
                if (io_axi_r_valid && io_axi_r_last) r_state_d = StRWait;
            end
            // One dead cycle so the still-high r_valid does not relaunch the refill
            StRWait: r_state_d = StRIdle;
            default: r_state_d = StRIdle;
        endcase
    end

    always_comb begin
        w_state_d            = w_state_q;
        waddr_d              = waddr_q;
        io_axi_aw_valid      = 1'b0;
        io_axi_w_valid       = 1'b0;
        io_cache_bus_w_ready = 1'b0;
        io_cache_bus_b_valid = 1'b0;
        io_axi_b_ready       = 1'b0;
        unique case (w_state_q)
            StWIdle: begin
                if (io_cache_bus_w_valid) begin
                    waddr_d   = io_cache_bus_w_bits_waddr;
                    w_state_d = StWAddr;
                end
            end
            StWAddr: begin
                io_axi_aw_valid = 1'b1;
                if (io_axi_aw_ready) w_state_d = StWData;
            end
            StWData: begin
                io_axi_w_valid       = io_cache_bus_w_valid;
                io_cache_bus_w_ready = io_axi_w_ready;
                if (io_cache_bus_w_valid && io_axi_w_ready && io_cache_bus_w_bits_wlast) begin
                    w_state_d = StWResp;
                end
            end
            StWResp: begin
                io_cache_bus_b_valid = io_axi_b_valid;
                io_axi_b_ready       = io_cache_bus_b_ready;
                if (io_axi_b_valid && io_cache_bus_b_ready) w_state_d = StWIdle;
            end
            default: w_state_d = StWIdle;
        endcase
    end

`ifdef DCACHE_AXI_BRIDGE_ERR_EN
    logic        err_q, err_d;
    logic [63:0] err_addr_q, err_addr_d;
    logic        err_is_w_q, err_is_w_d;

    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        err_is_w_d = err_is_w_q;
        // First error wins; later ones are dropped until reset
        if (!err_q) begin
            if (w_state_q == StWResp && io_axi_b_valid && io_cache_bus_b_ready &&
                io_axi_b_resp != 2'b00) begin
                err_d      = 1'b1;
                err_addr_d = waddr_q;
                err_is_w_d = 1'b1;
            end else if (r_state_q == StRData && io_axi_r_valid && io_axi_r_resp != 2'b00) begin
                err_d      = 1'b1;
                err_addr_d = raddr_q;
                err_is_w_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_is_w_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_is_w_q <= err_is_w_d;
        end
    end

    assign io_err      = err_q;
    assign io_err_addr = err_addr_q;
    assign io_err_is_w = err_is_w_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{io_axi_r_id, io_axi_b_id, io_axi_r_resp, io_axi_b_resp, raddr_q, waddr_q};

endmodule
